// File: rtl/tone_seq_pkg.sv
// Shared types and constants for the tone sequencer: FSM encodings, note-table
// entry layout and a width helper.
package tone_seq_pkg;

    localparam int unsigned DIV_W   = 32;
    localparam int unsigned DUR_W   = 4;
    localparam int unsigned ENTRY_W = 1 + DUR_W + DIV_W;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_LOAD = 2'd1;
    localparam state_t ST_PLAY = 2'd2;

    typedef struct packed {
        logic             rest;
        logic [DUR_W-1:0] dur;
        logic [DIV_W-1:0] divider;
    } note_entry_t;

    // Bits needed to hold 0..value-1; never returns less than 1.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned r;
        r = 0;
        while ((r < 32) && ((64'd1 << r) < 64'(value))) begin
            r = r + 1;
        end
        return (r == 0) ? 32'd1 : r;
    endfunction

endpackage

// File: rtl/tone_sequencer_square_wave_gen.sv
// Free-running phase counter that toggles a square wave every `divider` cycles.
// The next-cycle wave value is exported so the caller can register a muted copy.
module square_wave_gen
    import tone_seq_pkg::*;
(
    input  logic             CLK_50M,
    input  logic             reset,
    input  logic             clear,
    input  logic             enable,
    input  logic [DIV_W-1:0] divider,
    output logic             wave_nxt_c
);

    localparam int unsigned PW = DIV_W + 1;

    logic [DIV_W-1:0] phase;
    logic [DIV_W-1:0] phase_nxt_c;
    logic             wave;
    logic             wrap_c;

    // Wrap after divider-1; a zero divider wraps every cycle (output is muted then).
    assign wrap_c = (PW'(phase) + PW'(1)) >= PW'(divider);

    always_comb begin
        phase_nxt_c = phase;
        wave_nxt_c  = wave;
        if (clear) begin
            phase_nxt_c = '0;
            wave_nxt_c  = 1'b0;
        end else if (enable) begin
            if (wrap_c) begin
                phase_nxt_c = '0;
                wave_nxt_c  = ~wave;
            end else begin
                phase_nxt_c = phase + DIV_W'(1);
            end
        end
    end

    always_ff @(posedge CLK_50M) begin
        if (reset) begin
            phase <= '0;
            wave  <= 1'b0;
        end else begin
            phase <= phase_nxt_c;
            wave  <= wave_nxt_c;
        end
    end

endmodule

// File: rtl/tone_sequencer.sv
// Table-driven square-wave song player: a writable note RAM walked by an
// IDLE/LOAD/PLAY FSM, with per-note rest, duration and articulation gap.
module tone_sequencer
    import tone_seq_pkg::*;
#(
    parameter  int unsigned DEPTH      = 64,
    parameter  int unsigned BEAT_DIV   = 12500000,
    parameter  int unsigned GAP_CYCLES = 625000,
    localparam int unsigned AW         = clog2(DEPTH)
) (
    input  logic               CLK_50M,
    input  logic               reset,
    input  logic               start,
    input  logic               stop,
    input  logic               loop_mode,
    input  logic [AW-1:0]      last_idx,
    input  logic               wr_en,
    input  logic [AW-1:0]      wr_addr,
    input  logic [ENTRY_W-1:0] wr_data,
    output logic               song_output,
    output logic               playing,
    output logic [AW-1:0]      note_idx,
    output logic               done
);

    localparam int unsigned CNT_W = DUR_W + clog2(BEAT_DIV + 1);
    localparam int unsigned CMP_W = ((CNT_W > 32) ? CNT_W : 32) + 1;

    note_entry_t mem [DEPTH];
    note_entry_t cur;

    state_t           state;
    state_t           state_d;
    logic [AW-1:0]    note_idx_d;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_d;
    logic             song_d;
    logic             playing_d;
    logic             done_d;

    logic [DUR_W-1:0] dur_eff_c;
    logic [CNT_W-1:0] note_len_c;
    logic             last_cyc_c;
    logic             gap_nxt_c;
    logic             mute_nxt_c;
    logic             wave_nxt_c;

    // Note RAM: write any time, read captured only in LOAD so a rewrite of the
    // playing entry is heard from its next LOAD onward.
    always_ff @(posedge CLK_50M) begin
        if (wr_en) begin
            mem[wr_addr] <= note_entry_t'(wr_data);
        end
        if (state == ST_LOAD) begin
            cur <= mem[note_idx];
        end
    end

    square_wave_gen u_wave (
        .CLK_50M    (CLK_50M),
        .reset      (reset),
        .clear      (state != ST_PLAY),
        .enable     (state == ST_PLAY),
        .divider    (cur.divider),
        .wave_nxt_c (wave_nxt_c)
    );

    // cnt counts elapsed PLAY cycles; remaining = note_len - cnt.
    assign dur_eff_c  = (cur.dur == '0) ? DUR_W'(1) : cur.dur;
    assign note_len_c = CNT_W'(dur_eff_c) * CNT_W'(BEAT_DIV);
    assign last_cyc_c = (cnt == (note_len_c - CNT_W'(1)));
    assign gap_nxt_c  = (CMP_W'(cnt) + CMP_W'(1) + CMP_W'(GAP_CYCLES)) >= CMP_W'(note_len_c);
    assign mute_nxt_c = cur.rest | (cur.divider == '0) | gap_nxt_c;

    always_comb begin
        state_d    = state;
        note_idx_d = note_idx;
        cnt_d      = cnt;
        song_d     = 1'b0;
        done_d     = 1'b0;

        case (state)
            ST_IDLE: begin
                cnt_d      = '0;
                note_idx_d = '0;
                if (start) begin
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                cnt_d   = '0;
                state_d = ST_PLAY;
            end
            ST_PLAY: begin
                if (last_cyc_c) begin
                    cnt_d = '0;
                    if (note_idx != last_idx) begin
                        note_idx_d = note_idx + AW'(1);
                        state_d    = ST_LOAD;
                    end else if (loop_mode) begin
                        note_idx_d = '0;
                        state_d    = ST_LOAD;
                    end else begin
                        note_idx_d = '0;
                        done_d     = 1'b1;
                        state_d    = ST_IDLE;
                    end
                end else begin
                    cnt_d  = cnt + CNT_W'(1);
                    song_d = wave_nxt_c & ~mute_nxt_c;
                end
            end
            default: begin
                state_d    = ST_IDLE;
                note_idx_d = '0;
                cnt_d      = '0;
            end
        endcase

        if (stop) begin
            state_d    = ST_IDLE;
            note_idx_d = '0;
            cnt_d      = '0;
            song_d     = 1'b0;
            done_d     = 1'b0;
        end

        playing_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge CLK_50M) begin
        if (reset) begin
            state       <= ST_IDLE;
            note_idx    <= '0;
            cnt         <= '0;
            song_output <= 1'b0;
            playing     <= 1'b0;
            done        <= 1'b0;
        end else begin
            state       <= state_d;
            note_idx    <= note_idx_d;
            cnt         <= cnt_d;
            song_output <= song_d;
            playing     <= playing_d;
            done        <= done_d;
        end
    end

endmodule

// File: tb/tb_tone_sequencer.sv
// Directed scoreboard bench for tone_sequencer (BEAT_DIV=8, GAP_CYCLES=2, DEPTH=8).
module tb_tone_sequencer;
    import tone_seq_pkg::*;

    localparam int unsigned BEAT  = 8;
    localparam int unsigned GAP   = 2;
    localparam int unsigned DEPTH = 8;
    localparam int unsigned AW    = 3;

    typedef struct packed {
        logic          so;
        logic          pl;
        logic [AW-1:0] idx;
        logic          dn;
    } obs_t;

    logic               CLK_50M;
    logic               reset;
    logic               start;
    logic               stop;
    logic               loop_mode;
    logic [AW-1:0]      last_idx;
    logic               wr_en;
    logic [AW-1:0]      wr_addr;
    logic [ENTRY_W-1:0] wr_data;
    logic               song_output;
    logic               playing;
    logic [AW-1:0]      note_idx;
    logic               done;

    obs_t  q[$];
    int    total;
    int    passes;
    int    fails;
    int    cyc;
    string tag;

    tone_sequencer #(
        .DEPTH      (DEPTH),
        .BEAT_DIV   (BEAT),
        .GAP_CYCLES (GAP)
    ) dut (
        .CLK_50M     (CLK_50M),
        .reset       (reset),
        .start       (start),
        .stop        (stop),
        .loop_mode   (loop_mode),
        .last_idx    (last_idx),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .song_output (song_output),
        .playing     (playing),
        .note_idx    (note_idx),
        .done        (done)
    );

    initial CLK_50M = 1'b0;
    always #5 CLK_50M = ~CLK_50M;

    task automatic step();
        obs_t e;
        obs_t o;
        @(posedge CLK_50M);
        #1;
        cyc++;
        if (q.size() > 0) begin
            e = q.pop_front();
            o = '{so: song_output, pl: playing, idx: note_idx, dn: done};
            total++;
            assert (o === e) passes++;
            else begin
                fails++;
                $error("FAIL %s cyc %0d: {out,playing,idx,done} got %b req %b", tag, cyc, o, e);
            end
        end
    endtask

    // Expected LOAD cycle plus PLAY cycles of one note, truncated to cnt entries.
    task automatic push_part(input int idx, input bit r, input int d, input int dv, input int cnt);
        obs_t e;
        int   n;
        n = ((d == 0) ? 1 : d) * BEAT;
        for (int k = -1; (k < n) && ((k + 1) < cnt); k++) begin
            e.so = 1'b0;
            if ((k >= 0) && !r && (dv != 0) && ((n - k) > GAP)) e.so = ((k / dv) % 2) == 1;
            e.pl  = 1'b1;
            e.idx = AW'(idx);
            e.dn  = 1'b0;
            q.push_back(e);
        end
    endtask

    task automatic push_note(input int idx, input bit r, input int d, input int dv);
        push_part(idx, r, d, dv, 1000);
    endtask

    task automatic push_done();
        obs_t e;
        e = '{so: 1'b0, pl: 1'b0, idx: '0, dn: 1'b1};
        q.push_back(e);
    endtask

    task automatic push_idle();
        obs_t e;
        e = '{so: 1'b0, pl: 1'b0, idx: '0, dn: 1'b0};
        q.push_back(e);
    endtask

    task automatic wr(input int a, input bit r, input int d, input int dv);
        wr_addr = AW'(a);
        wr_data = {r, DUR_W'(d), DIV_W'(dv)};
        wr_en   = 1'b1;
        step();
        wr_en   = 1'b0;
    endtask

    // Drain the scoreboard, firing one-cycle events when the queue hits given depths.
    task automatic run_q(input int stop_at, input int clr_at, input int start_at,
                         input int rst_at, input int wr_at, input logic [ENTRY_W-1:0] wdata);
        int guard;
        guard = 0;
        while ((q.size() > 0) && (guard < 3000)) begin
            step();
            guard++;
            start = 1'b0;
            stop  = 1'b0;
            reset = 1'b0;
            wr_en = 1'b0;
            if (q.size() == stop_at)  stop = 1'b1;
            if (q.size() == clr_at)   loop_mode = 1'b0;
            if (q.size() == start_at) start = 1'b1;
            if (q.size() == rst_at)   reset = 1'b1;
            if (q.size() == wr_at) begin
                wr_en   = 1'b1;
                wr_addr = '0;
                wr_data = wdata;
            end
        end
        start = 1'b0;
        stop  = 1'b0;
        reset = 1'b0;
        wr_en = 1'b0;
        total++;
        assert (q.size() == 0) passes++;
        else begin
            fails++;
            $error("FAIL %s drain: entries left %0d req 0", tag, q.size());
        end
        q.delete();
    endtask

    initial begin
        total = 0; passes = 0; fails = 0; cyc = 0;
        reset = 1'b1; start = 1'b0; stop = 1'b0; loop_mode = 1'b0;
        last_idx = '0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        step();
        step();

        tag = "reset";
        push_idle();
        run_q(-1, -1, -1, -1, -1, '0);

        tag = "start_stop_same";
        push_idle();
        start = 1'b1; stop = 1'b1;
        run_q(-1, -1, -1, -1, -1, '0);

        tag = "single_note";
        wr(0, 1'b0, 2, 3);
        last_idx = 3'd0; loop_mode = 1'b0;
        push_note(0, 1'b0, 2, 3); push_done(); push_idle();
        start = 1'b1;
        run_q(-1, -1, 10, -1, -1, '0);

        tag = "rest_zero_div";
        wr(0, 1'b1, 1, 5);
        wr(1, 1'b0, 1, 0);
        last_idx = 3'd1;
        push_note(0, 1'b1, 1, 5); push_note(1, 1'b0, 1, 0); push_done(); push_idle();
        start = 1'b1;
        run_q(-1, -1, -1, -1, -1, '0);

        tag = "loop_wrap";
        wr(0, 1'b0, 1, 2);
        wr(1, 1'b0, 1, 3);
        wr(2, 1'b0, 1, 1);
        last_idx = 3'd2; loop_mode = 1'b1;
        for (int p = 0; p < 3; p++) begin
            push_note(0, 1'b0, 1, 2); push_note(1, 1'b0, 1, 3); push_note(2, 1'b0, 1, 1);
        end
        push_done(); push_idle();
        start = 1'b1;
        run_q(-1, 5, -1, -1, -1, '0);

        tag = "dur_zero";
        wr(0, 1'b0, 0, 4);
        last_idx = 3'd0; loop_mode = 1'b0;
        push_note(0, 1'b0, 0, 4); push_done(); push_idle();
        start = 1'b1;
        run_q(-1, -1, -1, -1, -1, '0);

        tag = "stop_mid_note";
        wr(0, 1'b0, 1, 2);
        wr(1, 1'b0, 2, 3);
        last_idx = 3'd1;
        push_note(0, 1'b0, 1, 2); push_part(1, 1'b0, 2, 3, 7); push_idle();
        start = 1'b1;
        run_q(1, -1, -1, -1, -1, '0);
        push_idle(); push_idle();
        run_q(-1, -1, -1, -1, -1, '0);

        tag = "replay_after_stop";
        push_note(0, 1'b0, 1, 2); push_note(1, 1'b0, 2, 3); push_done(); push_idle();
        start = 1'b1;
        run_q(-1, -1, -1, -1, -1, '0);

        tag = "reset_mid_play";
        push_part(0, 1'b0, 1, 2, 5); push_idle();
        start = 1'b1;
        run_q(-1, -1, -1, 1, -1, '0);
        push_idle();
        run_q(-1, -1, -1, -1, -1, '0);

        tag = "replay_after_reset";
        push_note(0, 1'b0, 1, 2); push_note(1, 1'b0, 2, 3); push_done(); push_idle();
        start = 1'b1;
        run_q(-1, -1, -1, -1, -1, '0);

        tag = "write_playing_entry";
        loop_mode = 1'b1;
        push_note(0, 1'b0, 1, 2); push_note(1, 1'b0, 2, 3);
        push_note(0, 1'b0, 1, 4); push_note(1, 1'b0, 2, 3);
        push_done(); push_idle();
        start = 1'b1;
        run_q(-1, 8, -1, -1, 50, {1'b0, DUR_W'(1), DIV_W'(4)});

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
